rv_iopmp_match_sequencer: RTL and testbench
===========================================

Name: rv_iopmp_match_sequencer

Overview:
- Controller for the windowed IOPMP matching datapath: entry analyzers plus decision logic evaluate NUMBER_ENTRY_ANALYZERS entries per cycle at a given entry offset.
- Accepts one transaction check at a time and steps the entry offset window by window. Stops at the first window that yields a decision, which preserves lowest-index priority.
- Returns a registered allow/error response through a valid/ready handshake.
- Sits between the transaction front-end (request side) and the analyzer/decision-logic datapath. It also signals busy so register writes can be stalled during a scan.

Parameters:
- SID_WIDTH, 8, width of source ID.
- ADDR_WIDTH, 64, width of transaction address.
- NUMBER_ENTRIES, 32, total IOPMP entries; must be a multiple of NUMBER_ENTRY_ANALYZERS and ≤ 512.
- NUMBER_ENTRY_ANALYZERS, 8, entries evaluated per cycle. Window count W = NUMBER_ENTRIES/NUMBER_ENTRY_ANALYZERS.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- enable_i  in  1  IOPMP global enable; sampled at request acceptance
- req_valid_i  in  1  check request valid
- req_ready_o  out  1  sequencer can accept a request
- req_addr_i  in  ADDR_WIDTH  transaction address
- req_sid_i  in  SID_WIDTH  source ID
- req_access_i  in  3  access type (rv_iopmp_pkg::access_t)
- dl_addr_o  out  ADDR_WIDTH  registered address driven to analyzers
- dl_sid_o  out  SID_WIDTH  registered SID driven to decision logic
- dl_access_o  out  3  registered access type
- dl_enable_o  out  1  decision-logic enable; high only in SCAN
- entry_offset_o  out  9  current window base index
- dl_allow_i  in  1  decision logic: allow for current window
- dl_err_i  in  1  decision logic: error for current window
- dl_err_type_i  in  3  decision logic error type
- dl_err_entry_i  in  16  decision logic faulting entry index
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumer ready
- rsp_allow_o  out  1  transaction allowed
- rsp_err_o  out  1  transaction error
- rsp_err_type_o  out  3  error type
- rsp_err_entry_o  out  16  faulting entry index
- busy_o  out  1  scan/response in progress

Behaviour:
- Reset (synchronous, rst_i=1 at a clk_i edge):
  - State goes to IDLE.
  - All outputs are 0 except req_ready_o=1.
  - Reset mid-scan or mid-response drops the transaction; no response is issued.
- States: IDLE, SCAN, RESP.
- IDLE:
  - req_ready_o=1, busy_o=0.
  - On req_valid_i&&req_ready_o: register addr/sid/access into dl_*_o and set entry_offset_o=0.
  - If enable_i=1: go to SCAN.
  - If enable_i=0: go to RESP with allow=1, err=0, err_type=0, err_entry=0 (bypass).
- SCAN:
  - dl_enable_o=1, busy_o=1, req_ready_o=0.
  - The dl_* inputs are combinational from the registered outputs and are sampled every cycle.
  - If dl_allow_i=1: capture allow=1, err=0, then go to RESP.
  - Else if dl_err_i=1 and dl_err_type_i≠5: capture err=1 with type/entry, allow=0, then go to RESP (first-match deny).
  - Else if entry_offset_o = NUMBER_ENTRIES−NUMBER_ENTRY_ANALYZERS (last window): capture the dl result verbatim. If neither dl_allow_i nor dl_err_i is set, force err=1, type=5, entry=0. Go to RESP.
  - Otherwise: entry_offset_o += NUMBER_ENTRY_ANALYZERS and stay in SCAN.
  - A type-5 (no-hit) error on a non-last window is ignored.
- RESP:
  - rsp_valid_o=1 with the captured fields; busy_o=1.
  - Fields are held stable until rsp_ready_i=1, then go to IDLE and clear entry_offset_o to 0.
  - No new request is accepted in the same cycle as the response handshake (req_ready_o=0 in RESP).
- Latency, accept edge to rsp_valid_o high:
  - 1 cycle when bypassed.
  - k+2 cycles for a decision in window k (0-based).
  - Maximum W+1 cycles.
- Invariants:
  - rsp_allow_o and rsp_err_o are never both 1.
  - entry_offset_o is always a multiple of NUMBER_ENTRY_ANALYZERS and < NUMBER_ENTRIES.
- Arithmetic: offset is 9-bit unsigned; never wraps given the parameter constraint.

Optional Feature:
- Macro: RV_IOPMP_SEQ_CONST_LATENCY_EN.
- Defined:
  - SCAN always visits all W windows, so latency is W+1 cycles regardless of hit position (timing side-channel hardening).
  - The first decisive window result (allow, or error with type≠5) is latched and later windows cannot overwrite it.
  - If no decisive result occurs, the last-window rule applies.
- Undefined: early-exit behaviour as specified above.

Test Plan (NUMBER_ENTRIES=32, ANALYZERS=8, W=4):
- Reset then idle: after rst_i pulse → req_ready_o=1, rsp_valid_o=0, busy_o=0, entry_offset_o=0.
- Allow in window 0 (dl_allow_i=1 at offset 0), sid=1 → rsp_valid_o 2 cycles after accept, allow=1, err=0; offsets seen: 0 only.
- Deny at entry 19 (window 2: dl_err_i=1, type=1, entry=19 at offset 16), access=WRITE → offsets 0, 8, 16; response err=1, type=1, entry=19, latency 4.
- No hit anywhere (type 5 at offset 0, nothing afterwards) → offsets 0, 8, 16, 24; response err=1, type=5, latency 5.
- Bypass (enable_i=0) → response allow=1 after 1 cycle, dl_enable_o never asserted. Backpressure: rsp_ready_i=0 for 3 cycles → fields stable, req_ready_o=0 throughout.
- Reset mid-scan at offset 16 → next cycle IDLE, offset 0, no rsp_valid_o. With CONST_LATENCY defined: window-0 allow still yields latency 5, allow=1.

Source files
------------

// File: rtl/rv_iopmp_match_sequencer.sv
// Windowed IOPMP match sequencer: steps the analyzer window across all entries and returns
// a registered allow/error response. Optional macro RV_IOPMP_SEQ_CONST_LATENCY_EN scans all windows.
module rv_iopmp_match_sequencer #(
    parameter int unsigned SID_WIDTH              = 8,
    parameter int unsigned ADDR_WIDTH             = 64,
    parameter int unsigned NUMBER_ENTRIES         = 32,
    parameter int unsigned NUMBER_ENTRY_ANALYZERS = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [SID_WIDTH-1:0]  req_sid_i,
    input  logic [2:0]            req_access_i,
    output logic [ADDR_WIDTH-1:0] dl_addr_o,
    output logic [SID_WIDTH-1:0]  dl_sid_o,
    output logic [2:0]            dl_access_o,
    output logic                  dl_enable_o,
    output logic [8:0]            entry_offset_o,
    input  logic                  dl_allow_i,
    input  logic                  dl_err_i,
    input  logic [2:0]            dl_err_type_i,
    input  logic [15:0]           dl_err_entry_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_allow_o,
    output logic                  rsp_err_o,
    output logic [2:0]            rsp_err_type_o,
    output logic [15:0]           rsp_err_entry_o,
    output logic                  busy_o
);

    localparam logic [8:0] LastOffset = 9'(NUMBER_ENTRIES - NUMBER_ENTRY_ANALYZERS);
    localparam logic [8:0] Step       = 9'(NUMBER_ENTRY_ANALYZERS);
    localparam logic [2:0] ErrNoHit   = 3'd5;

    typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

    state_e      state_q;
    logic        last_win;
    logic        decisive;
    logic        win_allow;
    logic        win_err;
    logic [2:0]  win_err_type;
    logic [15:0] win_err_entry;
    logic        hit_q;

    assign last_win = (entry_offset_o == LastOffset);
    assign decisive = dl_allow_i || (dl_err_i && (dl_err_type_i != ErrNoHit));

    // Result of the current window; only meaningful when decisive or on the last window,
    // where a silent window becomes a forced no-hit error.
    always_comb begin
        win_allow     = dl_allow_i;
        win_err       = !dl_allow_i;
        win_err_type  = '0;
        win_err_entry = '0;
        if (!dl_allow_i) begin
            if (dl_err_i) begin
                win_err_type  = dl_err_type_i;
                win_err_entry = dl_err_entry_i;
            end else begin
                win_err_type  = ErrNoHit;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            req_ready_o     <= 1'b1;
            busy_o          <= 1'b0;
            dl_enable_o     <= 1'b0;
            dl_addr_o       <= '0;
            dl_sid_o        <= '0;
            dl_access_o     <= '0;
            entry_offset_o  <= '0;
            rsp_valid_o     <= 1'b0;
            rsp_allow_o     <= 1'b0;
            rsp_err_o       <= 1'b0;
            rsp_err_type_o  <= '0;
            rsp_err_entry_o <= '0;
            hit_q           <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        dl_addr_o      <= req_addr_i;
                        dl_sid_o       <= req_sid_i;
                        dl_access_o    <= req_access_i;
                        entry_offset_o <= '0;
                        req_ready_o    <= 1'b0;
                        busy_o         <= 1'b1;
                        hit_q          <= 1'b0;
                        if (enable_i) begin
                            state_q     <= StScan;
                            dl_enable_o <= 1'b1;
                        end else begin
                            state_q         <= StResp;
                            rsp_valid_o     <= 1'b1;
                            rsp_allow_o     <= 1'b1;
                            rsp_err_o       <= 1'b0;
                            rsp_err_type_o  <= '0;
                            rsp_err_entry_o <= '0;
                        end
                    end
                end
                StScan: begin
                    // hit_q keeps the first decisive window from being overwritten
                    if (!hit_q && (decisive || last_win)) begin
                        rsp_allow_o     <= win_allow;
                        rsp_err_o       <= win_err;
                        rsp_err_type_o  <= win_err_type;
                        rsp_err_entry_o <= win_err_entry;
                    end
`ifdef RV_IOPMP_SEQ_CONST_LATENCY_EN
                    if (decisive) begin
                        hit_q <= 1'b1;
                    end
                    if (last_win) begin
                        state_q     <= StResp;
                        dl_enable_o <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        hit_q       <= 1'b0;
                    end else begin
                        entry_offset_o <= entry_offset_o + Step;
                    end
`else
                    if (decisive || last_win) begin
                        state_q     <= StResp;
                        dl_enable_o <= 1'b0;
                        rsp_valid_o <= 1'b1;
                    end else begin
                        entry_offset_o <= entry_offset_o + Step;
                    end
`endif
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        state_q        <= StIdle;
                        rsp_valid_o    <= 1'b0;
                        busy_o         <= 1'b0;
                        req_ready_o    <= 1'b1;
                        entry_offset_o <= '0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_iopmp_match_sequencer.sv
// Scoreboard bench for rv_iopmp_match_sequencer: a window-table datapath model drives dl_*,
// expected responses are queued at issue and checked by an independent monitor.
module tb_rv_iopmp_match_sequencer;

    localparam int N = 32;
    localparam int A = 8;
    localparam int W = N / A;
`ifdef RV_IOPMP_SEQ_CONST_LATENCY_EN
    localparam bit ConstLat = 1'b1;
`else
    localparam bit ConstLat = 1'b0;
`endif

    typedef struct packed {
        logic        allow;
        logic        err;
        logic [2:0]  typ;
        logic [15:0] entry;
    } win_t;

    typedef struct {
        bit          allow;
        bit          err;
        logic [2:0]  typ;
        logic [15:0] entry;
        int          lat;
        int          vis;
        logic [63:0] addr;
        logic [7:0]  sid;
        logic [2:0]  acc;
        int          acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [63:0] req_addr_i = '0;
    logic [7:0]  req_sid_i = '0;
    logic [2:0]  req_access_i = '0;
    logic [63:0] dl_addr_o;
    logic [7:0]  dl_sid_o;
    logic [2:0]  dl_access_o;
    logic        dl_enable_o;
    logic [8:0]  entry_offset_o;
    logic        dl_allow_i;
    logic        dl_err_i;
    logic [2:0]  dl_err_type_i;
    logic [15:0] dl_err_entry_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic        rsp_allow_o;
    logic        rsp_err_o;
    logic [2:0]  rsp_err_type_o;
    logic [15:0] rsp_err_entry_o;
    logic        busy_o;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   stall_req = 0;
    win_t tbl [W];
    exp_t sb [$];

    rv_iopmp_match_sequencer #(
        .SID_WIDTH(8), .ADDR_WIDTH(64), .NUMBER_ENTRIES(N), .NUMBER_ENTRY_ANALYZERS(A)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_sid_i(req_sid_i), .req_access_i(req_access_i),
        .dl_addr_o(dl_addr_o), .dl_sid_o(dl_sid_o), .dl_access_o(dl_access_o),
        .dl_enable_o(dl_enable_o), .entry_offset_o(entry_offset_o),
        .dl_allow_i(dl_allow_i), .dl_err_i(dl_err_i), .dl_err_type_i(dl_err_type_i),
        .dl_err_entry_i(dl_err_entry_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_allow_o(rsp_allow_o),
        .rsp_err_o(rsp_err_o), .rsp_err_type_o(rsp_err_type_o),
        .rsp_err_entry_o(rsp_err_entry_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: the result of the window addressed by the current offset.
    always_comb begin
        dl_allow_i     = 1'b0;
        dl_err_i       = 1'b0;
        dl_err_type_i  = '0;
        dl_err_entry_i = '0;
        if (int'(entry_offset_o) / A < W) begin
            dl_allow_i     = tbl[int'(entry_offset_o) / A].allow;
            dl_err_i       = tbl[int'(entry_offset_o) / A].err;
            dl_err_type_i  = tbl[int'(entry_offset_o) / A].typ;
            dl_err_entry_i = tbl[int'(entry_offset_o) / A].entry;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // First decisive window wins; otherwise the last window is taken as-is, silence = no-hit.
    function automatic exp_t model(input bit en);
        exp_t e;
        int   d;
        e = '{default: 0};
        if (!en) begin
            e.allow = 1; e.lat = 1; e.vis = 0;
            return e;
        end
        d = -1;
        for (int w = 0; w < W; w++) begin
            if (d < 0 && (tbl[w].allow || (tbl[w].err && tbl[w].typ != 3'd5))) d = w;
        end
        if (d < 0) begin
            d = W - 1;
            e.err   = !tbl[d].allow;
            e.typ   = 3'd5;
            e.entry = tbl[d].err ? tbl[d].entry : 16'd0;
        end else if (tbl[d].allow) begin
            e.allow = 1;
        end else begin
            e.err = 1; e.typ = tbl[d].typ; e.entry = tbl[d].entry;
        end
        e.lat = ConstLat ? W + 1 : d + 2;
        e.vis = ConstLat ? W : d + 1;
        return e;
    endfunction

    task automatic wait_idle();
        int g = 0;
        while (!req_ready_o && g < 200) begin
            @(posedge clk); #1; g++;
        end
        if (!req_ready_o) check("idle_timeout", 64'(req_ready_o), 64'd1);
    endtask

    task automatic issue(input bit en, input logic [7:0] sid, input logic [63:0] addr,
                         input logic [2:0] acc, input int stall, input bit track);
        exp_t e;
        stall_req    = stall;
        req_valid_i  = 1'b1;
        enable_i     = en;
        req_sid_i    = sid;
        req_addr_i   = addr;
        req_access_i = acc;
        @(posedge clk); #1;
        req_valid_i  = 1'b0;
        enable_i     = 1'($urandom);
        req_addr_i   = {$urandom, $urandom};
        req_sid_i    = 8'($urandom);
        if (track) begin
            e = model(en);
            e.addr = addr; e.sid = sid; e.acc = acc; e.acc_cyc = cyc;
            sb.push_back(e);
        end
    endtask

    // Response consumer: directed stalls first, then random backpressure.
    always @(posedge clk) begin
        #2;
        if (rsp_valid_o && stall_req > 0) begin
            rsp_ready_i = 1'b0;
            stall_req--;
        end else begin
            rsp_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor
    int          offs_seen = 0;
    bit          in_rsp = 0;
    bit          hold = 0;
    logic [20:0] snap;
    always @(negedge clk) begin
        exp_t e;
        if (rst_i) begin
            offs_seen = 0; in_rsp = 0; hold = 0;
        end else begin
            if (dl_enable_o) begin
                check("scan_offset", 64'(entry_offset_o), 64'(offs_seen * A));
                check("scan_busy_ready", {busy_o, req_ready_o}, 2'b10);
                offs_seen++;
            end
            if (hold) begin
                check("hold_valid", 64'(rsp_valid_o), 64'd1);
                check("hold_fields", {rsp_allow_o, rsp_err_o, rsp_err_type_o, rsp_err_entry_o},
                      snap);
                check("hold_req_ready", 64'(req_ready_o), 64'd0);
            end
            if (rsp_valid_o) begin
                check("rsp_excl", 64'(rsp_allow_o & rsp_err_o), 64'd0);
                check("rsp_busy", 64'(busy_o), 64'd1);
            end
            if (rsp_valid_o && !in_rsp) begin
                in_rsp = 1;
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_valid_o), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_allow", 64'(rsp_allow_o), 64'(e.allow));
                    check("rsp_err", 64'(rsp_err_o), 64'(e.err));
                    if (e.err || !e.allow) begin
                        check("rsp_err_type", 64'(rsp_err_type_o), 64'(e.typ));
                        check("rsp_err_entry", 64'(rsp_err_entry_o), 64'(e.entry));
                    end
                    check("latency", 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
                    check("windows_visited", 64'(offs_seen), 64'(e.vis));
                    check("dl_addr", dl_addr_o, e.addr);
                    check("dl_sid_acc", {dl_sid_o, dl_access_o}, {e.sid, e.acc});
                end
                offs_seen = 0;
            end
            hold = rsp_valid_o && !rsp_ready_i;
            snap = {rsp_allow_o, rsp_err_o, rsp_err_type_o, rsp_err_entry_o};
            if (rsp_valid_o && rsp_ready_i) in_rsp = 0;
        end
    end

    task automatic clear_tbl();
        for (int w = 0; w < W; w++) tbl[w] = '0;
    endtask

    initial begin
        int g;
        clear_tbl();
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        check("reset_req_ready", 64'(req_ready_o), 64'd1);
        check("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_offset", 64'(entry_offset_o), 64'd0);
        check("reset_dl_enable", 64'(dl_enable_o), 64'd0);

        // Allow in window 0
        wait_idle(); clear_tbl();
        tbl[0] = '{allow: 1'b1, err: 1'b0, typ: 3'd0, entry: 16'd0};
        issue(1'b1, 8'd1, 64'h1000, 3'd1, 0, 1'b1);
        // Deny at entry 19 (window 2), write access
        wait_idle(); clear_tbl();
        tbl[2] = '{allow: 1'b0, err: 1'b1, typ: 3'd1, entry: 16'd19};
        issue(1'b1, 8'd2, 64'h2000, 3'd2, 0, 1'b1);
        // No hit anywhere; type-5 on window 0 is ignored
        wait_idle(); clear_tbl();
        tbl[0] = '{allow: 1'b0, err: 1'b1, typ: 3'd5, entry: 16'd3};
        issue(1'b1, 8'd3, 64'h3000, 3'd1, 0, 1'b1);
        // Bypass with 3 cycles of backpressure
        wait_idle(); clear_tbl();
        tbl[1] = '{allow: 1'b0, err: 1'b1, typ: 3'd2, entry: 16'd9};
        issue(1'b0, 8'd4, 64'h4000, 3'd4, 3, 1'b1);

        // Reset mid-scan at offset 16: the transaction is dropped
        wait_idle(); clear_tbl();
        issue(1'b1, 8'd5, 64'h5000, 3'd1, 0, 1'b0);
        g = 0;
        while (entry_offset_o != 9'd16 && g < 10) begin
            @(posedge clk); #1; g++;
        end
        check("reach_offset16", 64'(entry_offset_o), 64'd16);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        check("midreset_offset", 64'(entry_offset_o), 64'd0);
        check("midreset_ready_busy", {req_ready_o, busy_o, dl_enable_o}, 3'b100);
        for (int i = 0; i < 6; i++) begin
            check("midreset_no_rsp", 64'(rsp_valid_o), 64'd0);
            @(posedge clk); #1;
        end

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            wait_idle(); clear_tbl();
            for (int w = 0; w < W; w++) begin
                case ($urandom_range(0, 7))
                    0: tbl[w] = '{1'b1, 1'($urandom), 3'($urandom), 16'($urandom)};
                    1, 2: tbl[w] = '{1'b0, 1'b1, 3'($urandom_range(0, 7)),
                                     16'(w * A + $urandom_range(0, A - 1))};
                    3: tbl[w] = '{1'b0, 1'b1, 3'd5, 16'(w * A + $urandom_range(0, A - 1))};
                    default: tbl[w] = '0;
                endcase
            end
            issue($urandom_range(0, 4) != 0, 8'($urandom), {$urandom, $urandom},
                  3'($urandom), $urandom_range(0, 2), 1'b1);
        end

        g = 0;
        while (sb.size() != 0 && g < 500) begin
            @(posedge clk); #1; g++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        wait_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
